// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer for the pipelined CPU fetch unit.
// Latches level requests, applies a mask, stalls fetch until the pipeline
// drains, then issues a single handler-entry pulse and later the return pulse
// (int_code 0) when decode retires RTI. Handlers never nest because the fetch
// unit holds only one return PC.
module interrupt_sequencer #(
   parameter int NUM_IRQ      = 15,
   parameter int CODE_W       = 4,
   parameter int GUARD_CYCLES = 2
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               pipe_empty,
   input  logic               rti_valid,
   input  logic               halted,
   output logic               fetch_stall,
   output logic               interrupt,
   output logic [CODE_W-1:0]  int_code,
   output logic               flush,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask
);

   // A zero guard length still needs a one-bit counter to stay legal.
   localparam int GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_DISPATCH,
      ST_SERVICE,
      ST_RETURN
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [NUM_IRQ-1:0]   enabled;
   logic                 any_enabled;
   logic [CODE_W-1:0]    winner;
   logic [NUM_IRQ-1:0]   winner_onehot;
   logic [NUM_IRQ-1:0]   clr;
   logic [GUARD_W-1:0]   guard;

   assign enabled     = pending & mask;
   assign any_enabled = |enabled;

   // Lowest enabled code wins; scanning downward lets the lowest index overwrite.
   always_comb begin
      winner        = '0;
      winner_onehot = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (enabled[i]) begin
            winner           = CODE_W'(i + 1);
            winner_onehot    = '0;
            winner_onehot[i] = 1'b1;
         end
      end
   end

   // State register; reset abandons any sequence in flight without a pulse.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode; outputs depend only on state and latched vectors.
   always_comb begin
      next_state  = state;
      fetch_stall = 1'b0;
      interrupt   = 1'b0;
      int_code    = '0;
      flush       = 1'b0;
      in_service  = 1'b0;
      clr         = '0;
      case (state)
         ST_IDLE: begin
            if (any_enabled && !halted && (guard == '0)) begin
               next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            fetch_stall = 1'b1;
            if (halted || !any_enabled) begin
               next_state = ST_IDLE;
            end else if (pipe_empty) begin
               next_state = ST_DISPATCH;
            end
         end
         ST_DISPATCH: begin
            interrupt  = 1'b1;
            int_code   = winner;
            flush      = 1'b1;
            clr        = winner_onehot;
            next_state = ST_SERVICE;
         end
         ST_SERVICE: begin
            in_service = 1'b1;
            if (rti_valid) begin
               next_state = ST_RETURN;
            end
         end
         ST_RETURN: begin
            interrupt  = 1'b1;
            flush      = 1'b1;
            in_service = 1'b1;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Request latch: sticky until dispatched; the dispatch clear beats a same-cycle request.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         pending <= '0;
      end else begin
         pending <= (pending | irq) & ~clr;
      end
   end

   // Mask register, writable in any state.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         mask <= '0;
      end else if (mask_we) begin
         mask <= mask_wdata;
      end
   end

   // Post-return guard so the handler's caller always makes forward progress.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         guard <= '0;
      end else if (state == ST_RETURN) begin
         guard <= GUARD_W'(GUARD_CYCLES);
      end else if (guard != '0) begin
         guard <= guard - GUARD_W'(1);
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: a flag-based behavioural model
// is compared against every output each cycle, and directed scenarios queue
// hand-computed literal expectations that are checked in the same sample.
module tb_interrupt_sequencer;

   localparam int NUM_IRQ      = 15;
   localparam int CODE_W       = 4;
   localparam int GUARD_CYCLES = 2;

   localparam int F_STALL = 0;
   localparam int F_INT   = 1;
   localparam int F_CODE  = 2;
   localparam int F_FLUSH = 3;
   localparam int F_SERV  = 4;
   localparam int F_PEND  = 5;
   localparam int F_MASK  = 6;

   logic               clk = 1'b0;
   logic               n_rst;
   logic [NUM_IRQ-1:0] irq;
   logic               mask_we;
   logic [NUM_IRQ-1:0] mask_wdata;
   logic               pipe_empty;
   logic               rti_valid;
   logic               halted;
   logic               fetch_stall;
   logic               interrupt;
   logic [CODE_W-1:0]  int_code;
   logic               flush;
   logic               in_service;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] mask;

   typedef struct {
      string name;
      int    sel;
      int    value;
   } lit_t;

   lit_t lit_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   chk_en   = 1'b0;

   interrupt_sequencer #(
      .NUM_IRQ(NUM_IRQ),
      .CODE_W(CODE_W),
      .GUARD_CYCLES(GUARD_CYCLES)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .irq(irq),
      .mask_we(mask_we),
      .mask_wdata(mask_wdata),
      .pipe_empty(pipe_empty),
      .rti_valid(rti_valid),
      .halted(halted),
      .fetch_stall(fetch_stall),
      .interrupt(interrupt),
      .int_code(int_code),
      .flush(flush),
      .in_service(in_service),
      .pending(pending),
      .mask(mask)
   );

   always #5 clk = ~clk;

   // Behavioural model: latched vectors plus one flag per activity.
   logic [NUM_IRQ-1:0] m_pend;
   logic [NUM_IRQ-1:0] m_mask;
   int                 m_guard;
   bit                 m_wait;
   bit                 m_entry;
   bit                 m_serv;
   bit                 m_ret;
   logic [NUM_IRQ-1:0] m_vis;
   logic [NUM_IRQ-1:0] m_low;
   logic [NUM_IRQ-1:0] m_clr;
   bit                 m_idle;

   assign m_vis  = m_pend & m_mask;
   assign m_low  = m_vis & (~m_vis + 15'd1);
   assign m_clr  = m_entry ? m_low : '0;
   assign m_idle = !(m_wait || m_entry || m_serv || m_ret);

   function automatic int lowest_code(input logic [NUM_IRQ-1:0] v);
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (v[i]) return i + 1;
      end
      return 0;
   endfunction

   // Model update on the same edge the DUT uses.
   always @(posedge clk) begin
      if (!n_rst) begin
         m_pend  <= '0;
         m_mask  <= '0;
         m_guard <= 0;
         m_wait  <= 1'b0;
         m_entry <= 1'b0;
         m_serv  <= 1'b0;
         m_ret   <= 1'b0;
      end else begin
         m_pend  <= (m_pend | irq) & ~m_clr;
         if (mask_we) m_mask <= mask_wdata;
         m_guard <= m_ret ? GUARD_CYCLES : ((m_guard > 0) ? m_guard - 1 : 0);
         m_wait  <= (m_idle && (m_vis != 0) && !halted && (m_guard == 0)) ||
                    (m_wait && !halted && (m_vis != 0) && !pipe_empty);
         m_entry <= m_wait && !halted && (m_vis != 0) && pipe_empty;
         m_serv  <= m_entry || (m_serv && !rti_valid);
         m_ret   <= m_serv && rti_valid;
      end
   end

   function automatic logic [31:0] field_value(input int sel);
      case (sel)
         F_STALL: return {31'd0, fetch_stall};
         F_INT:   return {31'd0, interrupt};
         F_CODE:  return {28'd0, int_code};
         F_FLUSH: return {31'd0, flush};
         F_SERV:  return {31'd0, in_service};
         F_PEND:  return {17'd0, pending};
         default: return {17'd0, mask};
      endcase
   endfunction

   logic [37:0] exp_vec;
   logic [37:0] act_vec;
   logic [3:0]  exp_code;
   logic [31:0] lit_act;
   lit_t        lit_e;

   // Compare process: model check every cycle, then any queued literal checks.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_code = m_entry ? 4'(lowest_code(m_vis)) : 4'd0;
         exp_vec  = {m_wait, m_entry | m_ret, exp_code, m_entry | m_ret,
                     m_serv | m_ret, m_pend, m_mask};
         act_vec  = {fetch_stall, interrupt, int_code, flush, in_service, pending, mask};
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("[TB] FAIL model_compare t=%0t actual=%h required=%h",
                     $time, act_vec, exp_vec);
         end
         while (lit_q.size() > 0) begin
            lit_e   = lit_q.pop_front();
            lit_act = field_value(lit_e.sel);
            checks++;
            if (lit_act !== lit_e.value) begin
               failures++;
               $display("[TB] FAIL %s t=%0t actual=%0h required=%0h",
                        lit_e.name, $time, lit_act, lit_e.value);
            end
         end
      end
   end

   // Queue a literal expectation for the outputs of the current cycle.
   task automatic check_output(input string name, input int sel, input int value);
      lit_t e;
      e.name  = name;
      e.sel   = sel;
      e.value = value;
      lit_q.push_back(e);
   endtask

   // Advance to just after the next active edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input logic [NUM_IRQ-1:0] irq_v, input logic pe,
                                 input logic rti, input logic hlt);
      irq        = irq_v;
      pipe_empty = pe;
      rti_valid  = rti;
      halted     = hlt;
   endtask

   task automatic write_mask(input logic [NUM_IRQ-1:0] m);
      mask_we    = 1'b1;
      mask_wdata = m;
      step(1);
      mask_we    = 1'b0;
   endtask

   task automatic finish_handler();
      rti_valid = 1'b1;
      step(1);
      rti_valid = 1'b0;
      step(1);
   endtask

   initial begin
      n_rst      = 1'b0;
      mask_we    = 1'b0;
      mask_wdata = '0;
      apply_stimulus('0, 1'b1, 1'b0, 1'b0);
      step(2);
      chk_en = 1'b1;
      check_output("reset_stall", F_STALL, 0);
      check_output("reset_pending", F_PEND, 0);
      check_output("reset_mask", F_MASK, 0);
      n_rst = 1'b1;
      write_mask(15'h7fff);
      check_output("mask_loaded", F_MASK, 'h7fff);

      // Single request, minimum latency.
      irq = 15'h0004;
      step(1);
      irq = '0;
      check_output("t1_pending", F_PEND, 'h0004);
      check_output("t1_no_stall_yet", F_STALL, 0);
      step(1);
      check_output("t1_stall", F_STALL, 1);
      step(1);
      check_output("t1_pulse", F_INT, 1);
      check_output("t1_code", F_CODE, 3);
      check_output("t1_flush", F_FLUSH, 1);
      check_output("t1_pulse_stall", F_STALL, 0);
      step(1);
      check_output("t1_pending_clr", F_PEND, 0);
      check_output("t1_in_service", F_SERV, 1);
      rti_valid = 1'b1;
      step(1);
      rti_valid = 1'b0;
      check_output("t1_ret_pulse", F_INT, 1);
      check_output("t1_ret_code", F_CODE, 0);
      check_output("t1_ret_serv", F_SERV, 1);
      step(1);
      check_output("t1_idle", F_SERV, 0);

      // Two codes pending: priority and guard.
      step(3);
      irq = 15'h0012;
      step(1);
      irq = '0;
      check_output("t2_pending", F_PEND, 'h0012);
      step(2);
      check_output("t2_first_code", F_CODE, 2);
      step(1);
      check_output("t2_pending_left", F_PEND, 'h0010);
      rti_valid = 1'b1;
      step(1);
      rti_valid = 1'b0;
      check_output("t2_ret_code", F_CODE, 0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check_output("t2_guard_idle", F_STALL, 0);
      end
      step(1);
      check_output("t2_drain", F_STALL, 1);
      step(1);
      check_output("t2_second_code", F_CODE, 5);
      step(1);
      finish_handler();

      // Long drain.
      step(3);
      apply_stimulus(15'h0008, 1'b0, 1'b0, 1'b0);
      step(1);
      irq = '0;
      step(1);
      for (int i = 0; i < 6; i++) begin
         check_output("t3_hold_stall", F_STALL, 1);
         check_output("t3_hold_no_pulse", F_INT, 0);
         step(1);
      end
      pipe_empty = 1'b1;
      check_output("t3_last_stall", F_STALL, 1);
      step(1);
      check_output("t3_code", F_CODE, 4);
      step(1);
      finish_handler();

      // Mask write abandons the drain.
      step(3);
      write_mask(15'h0040);
      apply_stimulus(15'h0040, 1'b0, 1'b0, 1'b0);
      step(1);
      irq = '0;
      step(1);
      check_output("t4_drain", F_STALL, 1);
      write_mask(15'h0000);
      check_output("t4_still_drain", F_STALL, 1);
      check_output("t4_mask_zero", F_MASK, 0);
      step(1);
      check_output("t4_back_idle", F_STALL, 0);
      check_output("t4_pending_kept", F_PEND, 'h0040);
      step(2);
      check_output("t4_no_pulse", F_INT, 0);
      pipe_empty = 1'b1;

      // Request during service only latches; halted is held in service.
      write_mask(15'h7fbf);
      irq = 15'h0080;
      step(1);
      irq = '0;
      step(2);
      check_output("t5_code8", F_CODE, 8);
      step(1);
      apply_stimulus(15'h0001, 1'b1, 1'b0, 1'b1);
      step(1);
      check_output("t5_latched", F_PEND, 'h0041);
      step(2);
      check_output("t5_no_nest", F_INT, 0);
      check_output("t5_halt_held", F_SERV, 1);
      apply_stimulus('0, 1'b1, 1'b1, 1'b0);
      step(1);
      rti_valid = 1'b0;
      check_output("t5_ret_pulse", F_INT, 1);
      check_output("t5_ret_code", F_CODE, 0);
      check_output("t5_ret_flush", F_FLUSH, 1);
      step(4);
      check_output("t5_drain", F_STALL, 1);
      step(1);
      check_output("t5_code1", F_CODE, 1);
      step(1);
      finish_handler();

      // Reset mid-sequence and halted blocking entry.
      step(3);
      apply_stimulus(15'h0002, 1'b0, 1'b0, 1'b0);
      step(1);
      irq = '0;
      step(1);
      check_output("t6_drain", F_STALL, 1);
      n_rst = 1'b0;
      step(1);
      n_rst = 1'b1;
      check_output("t6_rst_stall", F_STALL, 0);
      check_output("t6_rst_pending", F_PEND, 0);
      check_output("t6_rst_mask", F_MASK, 0);
      pipe_empty = 1'b1;
      write_mask(15'h7fff);
      irq = 15'h0004;
      step(1);
      irq = '0;
      step(3);
      check_output("t6_service", F_SERV, 1);
      n_rst = 1'b0;
      step(1);
      n_rst = 1'b1;
      check_output("t6_rst_serv", F_SERV, 0);
      check_output("t6_rst_int", F_INT, 0);
      check_output("t6_rst_pend2", F_PEND, 0);
      halted = 1'b1;
      write_mask(15'h7fff);
      irq = 15'h0100;
      step(1);
      irq = '0;
      check_output("t6_halt_pending", F_PEND, 'h0100);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check_output("t6_halt_blocks", F_STALL, 0);
      end
      halted = 1'b0;
      step(1);
      check_output("t6_unhalt_drain", F_STALL, 1);
      step(1);
      check_output("t6_code9", F_CODE, 9);
      step(1);
      finish_handler();

      // RTI outside service is ignored.
      step(3);
      rti_valid = 1'b1;
      step(1);
      check_output("rti_idle_no_pulse", F_INT, 0);
      step(1);
      rti_valid = 1'b0;
      check_output("rti_idle_no_serv", F_SERV, 0);
      step(2);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
